// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: synchronizes and debounces a 3-bit hall code, counts signed
// commutation steps inside a measurement window and reports the count when the window closes.
`timescale 1ns/1ps

module hall_speed_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [2:0]       hall,
    output logic [CNT_W-1:0] speed,
    output logic             speed_valid,
    output logic             speed_err,
    output logic             dir
);

    localparam int unsigned HOLD_W = $clog2(FILT_LEN + 1);
    localparam logic [HOLD_W-1:0] FILT_MAX = HOLD_W'(FILT_LEN);
    localparam logic [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W - 1){1'b1}}};
    localparam logic [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W - 1){1'b0}}};

    // Synchronizer and debounce filter state
    logic [2:0]        sync1_q, sync2_q;
    logic [2:0]        cand_q;
    logic [HOLD_W-1:0] hold_q, run_len;
    logic [2:0]        filt_q;
    logic              accept;

    // Step decoding state
    logic [2:0]        new_idx;
    logic              new_valid;
    logic [2:0]        ref_q;
    logic              ref_valid_q;
    logic [2:0]        ref_up, ref_dn;
    logic              step_up, step_dn, fault_ev;

    // Window accumulator and output state
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              fault_q, fault_d;
    logic              dir_q, dir_d;
    logic              start_q;
    logic              fall;
    logic [CNT_W-1:0]  speed_q;
    logic              speed_valid_q;
    logic              speed_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= hall;
            sync2_q <= sync1_q;
        end
    end

    // run_len counts consecutive cycles the synchronized code has been stable, saturating.
    always_comb begin
        run_len = HOLD_W'(1);
        if (sync2_q == cand_q) begin
            run_len = (hold_q == FILT_MAX) ? hold_q : hold_q + 1'b1;
        end
        accept = (run_len == FILT_MAX) && (sync2_q != filt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= 3'b000;
            hold_q <= '0;
            filt_q <= 3'b000;
        end else begin
            cand_q <= sync2_q;
            hold_q <= run_len;
            if (accept) begin
                filt_q <= sync2_q;
            end
        end
    end

    always_comb begin
        new_valid = 1'b1;
        new_idx   = 3'd0;
        case (sync2_q)
            3'b101:  new_idx = 3'd0;
            3'b100:  new_idx = 3'd1;
            3'b110:  new_idx = 3'd2;
            3'b010:  new_idx = 3'd3;
            3'b011:  new_idx = 3'd4;
            3'b001:  new_idx = 3'd5;
            default: new_valid = 1'b0;
        endcase
    end

    always_comb begin
        ref_up   = (ref_q == 3'd5) ? 3'd0 : ref_q + 3'd1;
        ref_dn   = (ref_q == 3'd0) ? 3'd5 : ref_q - 3'd1;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        fault_ev = 1'b0;
        if (accept) begin
            if (!new_valid) begin
                fault_ev = 1'b1;
            end else if (ref_valid_q) begin
                if (new_idx == ref_up) begin
                    step_up = 1'b1;
                end else if (new_idx == ref_dn) begin
                    step_dn = 1'b1;
                end else begin
                    fault_ev = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q       <= 3'd0;
            ref_valid_q <= 1'b0;
        end else if (accept) begin
            if (new_valid) begin
                ref_q       <= new_idx;
                ref_valid_q <= 1'b1;
            end else begin
                ref_valid_q <= 1'b0;
            end
        end
    end

    // Steps only land while the window is open; clr wins over anything in the same cycle.
    always_comb begin
        acc_d   = acc_q;
        fault_d = fault_q | fault_ev;
        dir_d   = dir_q;
        if (clr) begin
            acc_d   = '0;
            fault_d = 1'b0;
        end else if (start) begin
            if (step_up) begin
                dir_d = 1'b1;
                if (acc_q != ACC_MAX) begin
                    acc_d = acc_q + CNT_W'(1);
                end
            end else if (step_dn) begin
                dir_d = 1'b0;
                if (acc_q != ACC_MIN) begin
                    acc_d = acc_q - CNT_W'(1);
                end
            end
        end
    end

    assign fall = start_q & ~start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            fault_q       <= 1'b0;
            dir_q         <= 1'b0;
            start_q       <= 1'b0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            speed_err_q   <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            fault_q       <= fault_d;
            dir_q         <= dir_d;
            start_q       <= start;
            speed_valid_q <= fall;
            if (fall) begin
                speed_q     <= acc_q;
                speed_err_q <= fault_q;
            end
        end
    end

    assign speed       = speed_q;
    assign speed_valid = speed_valid_q;
    assign speed_err   = speed_err_q;
    assign dir         = dir_q;

endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: directed windows plus randomized hall/timer traffic, checked
// every cycle against a history-based reference model for a 16-bit and a 4-bit counter.
`timescale 1ns/1ps

module tb_hall_speed_meter;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst, start, clr;
    logic [2:0]  hall;
    logic [15:0] speed16;
    logic [3:0]  speed4;
    logic        sv16, sv4, err16, err4, dir16, dir4;

    hall_speed_meter #(.CNT_W(16), .FILT_LEN(FL)) dut16 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .hall(hall),
        .speed(speed16), .speed_valid(sv16), .speed_err(err16), .dir(dir16)
    );

    hall_speed_meter #(.CNT_W(4), .FILT_LEN(FL)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .hall(hall),
        .speed(speed4), .speed_valid(sv4), .speed_err(err4), .dir(dir4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Codes in forward rotation order; position in this table is the electrical index.
    logic [2:0] fwd_codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    function automatic int code_idx(logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (fwd_codes[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference model: hq[k] is the hall value driven k cycles ago; the counting logic sees
    // hq[2] (two synchronizer stages) and accepts it once it has been seen FL cycles in a row.
    logic [2:0] hq [$];
    logic [2:0] m_last;
    int m_acc16, m_acc4, m_speed16, m_speed4, m_ref;
    bit m_fault, m_err, m_valid, m_dir, m_refv, m_start_prev;

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < FL + 2; i++) hq.push_back(3'b000);
        m_last = 3'b000;
        m_acc16 = 0; m_acc4 = 0; m_speed16 = 0; m_speed4 = 0; m_ref = 0;
        m_fault = 0; m_err = 0; m_valid = 0; m_dir = 0; m_refv = 0; m_start_prev = 0;
    endtask

    task automatic model_cycle();
        bit same, fall, flt;
        int step, idx, d;
        if (rst) begin
            model_reset();
            return;
        end
        hq.push_front(hall);
        void'(hq.pop_back());
        same = 1;
        for (int i = 3; i <= FL + 1; i++) if (hq[i] != hq[2]) same = 0;
        step = 0;
        flt  = 0;
        if (same && hq[2] != m_last) begin
            m_last = hq[2];
            idx = code_idx(hq[2]);
            if (idx < 0) begin
                flt = 1;
                m_refv = 0;
            end else begin
                if (m_refv) begin
                    d = (idx - m_ref + 6) % 6;
                    if (d == 1) step = 1;
                    else if (d == 5) step = -1;
                    else flt = 1;
                end
                m_ref  = idx;
                m_refv = 1;
            end
        end
        fall = m_start_prev && !start;
        m_valid = fall;
        if (fall) begin
            m_speed16 = m_acc16;
            m_speed4  = m_acc4;
            m_err     = m_fault;
        end
        if (clr) begin
            m_acc16 = 0;
            m_acc4  = 0;
            m_fault = 0;
        end else begin
            if (start && step != 0) begin
                m_acc16 = clampi(m_acc16 + step, -32768, 32767);
                m_acc4  = clampi(m_acc4 + step, -8, 7);
                m_dir   = (step > 0);
            end
            m_fault = m_fault | flt;
        end
        m_start_prev = start;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check_eq("valid16", sv16, m_valid);
        check_eq("valid4", sv4, m_valid);
        check_eq("err16", err16, m_err);
        check_eq("err4", err4, m_err);
        check_eq("dir16", dir16, m_dir);
        check_eq("dir4", dir4, m_dir);
        check_eq("speed16", speed16, m_speed16 & 32'hFFFF);
        check_eq("speed4", speed4, m_speed4 & 32'hF);
    endtask

    task automatic hold_code(logic [2:0] c, int n);
        hall = c;
        repeat (n) tick();
    endtask

    // Timer-style close: start falls at T, clr at T+1, start rises at T+2.
    task automatic close_window(string tag, int e16, int e4, bit e_err, bit e_dir);
        start = 1'b0;
        clr   = 1'b0;
        tick();
        check_eq({tag, "_valid"}, sv16, 1);
        check_eq({tag, "_speed16"}, speed16, e16 & 32'hFFFF);
        check_eq({tag, "_speed4"}, speed4, e4 & 32'hF);
        check_eq({tag, "_err"}, err16, e_err);
        check_eq({tag, "_dir"}, dir16, e_dir);
        clr = 1'b1;
        tick();
        check_eq({tag, "_pulse"}, sv16, 0);
        clr   = 1'b0;
        start = 1'b1;
    endtask

    int cur_idx;

    task automatic rand_hall_tick(inout int left);
        int r;
        if (left == 0) begin
            r = $urandom_range(0, 15);
            if (r < 2) begin
                hall = (r == 0) ? 3'b000 : 3'b111;
            end else begin
                if (r < 13) cur_idx = (cur_idx + ((r < 9) ? 1 : 5)) % 6;
                else cur_idx = $urandom_range(0, 5);
                hall = fwd_codes[cur_idx];
            end
            left = $urandom_range(1, 12);
        end
        left--;
        tick();
    endtask

    initial begin
        int left, len, gap, clr_at;
        rst   = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        hall  = 3'b101;
        model_reset();
        repeat (3) tick();
        check_eq("rst_speed", speed16, 0);
        check_eq("rst_valid", sv16, 0);
        check_eq("rst_err", err16, 0);
        check_eq("rst_dir", dir16, 0);
        rst = 1'b0;

        // Full forward revolution
        start = 1'b1;
        hold_code(3'b101, 10);
        for (int k = 1; k <= 6; k++) hold_code(fwd_codes[k % 6], 10);
        close_window("fwd", 6, 6, 0, 1);

        // Four reverse steps from 101
        for (int k = 1; k <= 4; k++) hold_code(fwd_codes[(6 - k) % 6], 10);
        close_window("rev", -4, -4, 0, 0);

        // Three-cycle glitch is filtered out
        hold_code(3'b010, 3);
        hold_code(3'b110, 10);
        close_window("glitch", 0, 0, 0, 0);

        // Invalid code, re-reference, one step; then a clean window
        hold_code(3'b111, 10);
        hold_code(3'b010, 10);
        hold_code(3'b011, 10);
        close_window("fault", 1, 1, 1, 1);
        hold_code(3'b001, 10);
        close_window("clean", 1, 1, 0, 1);

        // Ten forward steps saturate the 4-bit counter
        for (int k = 1; k <= 10; k++) hold_code(fwd_codes[(5 + k) % 6], 10);
        close_window("sat", 10, 7, 0, 1);

        // Steps accepted exactly at T, then exactly at T+1, are dropped
        hold_code(3'b011, FL + 1);
        close_window("drop_t", 0, 0, 0, 1);
        hold_code(3'b001, FL);
        close_window("drop_t1", 0, 0, 0, 1);
        hold_code(3'b101, 10);
        close_window("after_drop", 1, 1, 0, 1);

        // Reset mid-window aborts it; next window is normal
        hold_code(3'b100, 10);
        rst = 1'b1;
        repeat (2) tick();
        check_eq("midrst_valid", sv16, 0);
        check_eq("midrst_speed", speed16, 0);
        rst = 1'b0;
        hold_code(3'b100, 10);
        hold_code(3'b110, 10);
        close_window("post_rst", 1, 1, 0, 1);

        // Randomized traffic with variable windows, gaps, stray clr and occasional reset
        cur_idx = 2;
        left = 0;
        for (int w = 0; w < 40; w++) begin
            start = 1'b1;
            len = $urandom_range(15, 90);
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(0, 49) == 0);
                rst = ($urandom_range(0, 399) == 0);
                rand_hall_tick(left);
                rst = 1'b0;
            end
            start  = 1'b0;
            gap    = $urandom_range(1, 5);
            clr_at = $urandom_range(0, gap);
            for (int i = 0; i < gap; i++) begin
                clr = (i == clr_at);
                rand_hall_tick(left);
            end
            clr = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
